// File: rtl/video_freeze_ctrl_pkg.sv
// Shared types and defaults for the video freeze sequencer.
package video_freeze_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FROZEN  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLDOFF = 3'd4
  } vfc_state_t;

  localparam int unsigned VFC_TIMEOUT_DEF    = 3_000_000;
  localparam int unsigned VFC_MIN_FRAMES_DEF = 2;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vfc_sync_watch.sv
// Vsync input registers, rise detectors and the state watchdog counter.
module vfc_sync_watch #(
  parameter int unsigned     TO_W    = 22,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(3_000_000)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vs_in,
  input  logic i_vs_out,
  input  logic i_clr,
  output logic o_vs_rise,
  output logic o_frm_rise,
  output logic o_tc
);

  logic            r_vs_in;
  logic            r_vs_in_q;
  logic            r_vs_out;
  logic            r_vs_out_q;
  logic [TO_W-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_in    <= 1'b0;
      r_vs_in_q  <= 1'b0;
      r_vs_out   <= 1'b0;
      r_vs_out_q <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_vs_in    <= i_vs_in;
      r_vs_in_q  <= r_vs_in;
      r_vs_out   <= i_vs_out;
      r_vs_out_q <= r_vs_out;
      r_tmo      <= i_clr ? '0 : r_tmo + 1'b1;
    end
  end

  assign o_vs_rise  = r_vs_in & ~r_vs_in_q;
  assign o_frm_rise = r_vs_out & ~r_vs_out_q;
  assign o_tc       = (r_tmo == TIMEOUT - TO_W'(1));

endmodule

// File: rtl/video_freeze_ctrl.sv
// Vsync-aligned freeze arbiter for the shared video freezer.
// Optional post-release holdoff state: define VIDEO_FREEZE_CTRL_HOLDOFF_EN.
module video_freeze_ctrl
  import video_freeze_ctrl_pkg::*;
#(
  parameter int unsigned     NREQ       = 4,
  parameter int unsigned     TO_W       = 22,
  parameter logic [TO_W-1:0] TIMEOUT    = TO_W'(VFC_TIMEOUT_DEF),
  parameter int unsigned     MIN_FRAMES = VFC_MIN_FRAMES_DEF
`ifdef VIDEO_FREEZE_CTRL_HOLDOFF_EN
  , parameter int unsigned   HOLDOFF_FRAMES = 4
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] owner,
  input  logic                    vs_in,
  input  logic                    vs_out,
  input  logic                    lock_valid,
  output logic                    freeze,
  output logic                    frozen,
  output logic                    nolock
);

  localparam int unsigned    OW   = $clog2(NREQ);
  localparam int unsigned    FW   = $clog2(MIN_FRAMES + 2);
  localparam logic [FW-1:0]  MINF = FW'(MIN_FRAMES);
`ifdef VIDEO_FREEZE_CTRL_HOLDOFF_EN
  localparam int unsigned    HW    = $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [HW-1:0]  HLAST = HW'(HOLDOFF_FRAMES - 1);
  localparam vfc_state_t     ST_RELEASE = ST_HOLDOFF;
  logic [HW-1:0]             r_hcnt;
`else
  localparam vfc_state_t     ST_RELEASE = ST_IDLE;
`endif

  vfc_state_t      r_state;
  vfc_state_t      w_nxt;
  logic [FW-1:0]   r_fcnt;
  logic            r_frz;
  logic [NREQ-1:0] r_ack;
  logic [OW-1:0]   r_owner;
  logic            r_nolock;
  logic            w_vs_rise;
  logic            w_frm_rise;
  logic            w_tc;
  logic            w_clr;
  logic            w_req_any;

  assign w_req_any = |req;

  vfc_sync_watch #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watch (
    .clk        (clk),
    .reset      (reset),
    .i_vs_in    (vs_in),
    .i_vs_out   (vs_out),
    .i_clr      (w_clr),
    .o_vs_rise  (w_vs_rise),
    .o_frm_rise (w_frm_rise),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_any) w_nxt = ST_ARM;
      ST_ARM: begin
        if (!w_req_any)                  w_nxt = ST_IDLE;
        else if (lock_valid && w_vs_rise) w_nxt = ST_FROZEN;
        else if (w_tc)                    w_nxt = ST_FROZEN;
      end
      ST_FROZEN: if (!w_req_any && (r_fcnt >= MINF)) w_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_req_any)              w_nxt = ST_FROZEN;
        else if (w_vs_rise || w_tc) w_nxt = ST_RELEASE;
      end
`ifdef VIDEO_FREEZE_CTRL_HOLDOFF_EN
      ST_HOLDOFF: if (w_tc || (w_vs_rise && (r_hcnt == HLAST))) w_nxt = ST_IDLE;
`endif
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Source vsync only restarts the watchdog while waiting for an edge.
  assign w_clr = (w_nxt != r_state) ||
                 (w_vs_rise && ((r_state == ST_ARM) || (r_state == ST_DRAIN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_frz    <= 1'b0;
      r_ack    <= '0;
      r_owner  <= '0;
      r_nolock <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_frz   <= (w_nxt == ST_FROZEN) || (w_nxt == ST_DRAIN);
      r_ack   <= (r_state == ST_FROZEN) ? req : '0;
      if ((r_state == ST_FROZEN) && w_req_any)
        r_owner <= OW'(lowest_set(8'(req)));
      if ((r_state == ST_ARM) && (w_nxt == ST_FROZEN)) begin
        r_nolock <= ~(lock_valid & w_vs_rise);
        r_fcnt   <= '0;
      end else if ((r_state == ST_FROZEN) && w_frm_rise && (r_fcnt != MINF)) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

`ifdef VIDEO_FREEZE_CTRL_HOLDOFF_EN
  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_HOLDOFF)) r_hcnt <= '0;
    else if (w_vs_rise)                   r_hcnt <= r_hcnt + 1'b1;
  end
`endif

  assign freeze = r_frz;
  assign frozen = r_frz;
  assign ack    = r_ack;
  assign owner  = r_owner;
  assign nolock = r_nolock;

endmodule

// File: tb/tb_video_freeze_ctrl.sv
// Cycle-table and scoreboard bench for video_freeze_ctrl (TIMEOUT = 1000).
module tb_video_freeze_ctrl;

  typedef struct {
    logic       f;
    logic [3:0] ack;
    logic [1:0] own;
    logic       fr;
    logic       nl;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       vs;
    logic       vo;
    logic       lk;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] owner;
  logic       vs_in;
  logic       vs_out;
  logic       lock_valid;
  logic       freeze;
  logic       frozen;
  logic       nolock;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  exp_t        sb[$];
  vec_t        tbl_a[$];
  vec_t        tbl_b[$];

  video_freeze_ctrl #(
    .NREQ    (4),
    .TO_W    (22),
    .TIMEOUT (22'd1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .owner      (owner),
    .vs_in      (vs_in),
    .vs_out     (vs_out),
    .lock_valid (lock_valid),
    .freeze     (freeze),
    .frozen     (frozen),
    .nolock     (nolock)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic f, input logic [3:0] a, input logic [1:0] o,
                              input logic fr, input logic nl, input string n);
    exp_t e;
    e.f = f; e.ack = a; e.own = o; e.fr = fr; e.nl = nl; e.name = n;
    return e;
  endfunction

  function automatic vec_t mv(input logic rst, input logic [3:0] rq, input logic v,
                              input logic vo, input logic lk, input exp_t e);
    vec_t x;
    x.rst = rst; x.req = rq; x.vs = v; x.vo = vo; x.lk = lk; x.e = e;
    return x;
  endfunction

  task automatic step(input logic rst, input logic [3:0] rq, input logic v,
                      input logic vo, input logic lk, input exp_t e);
    exp_t x;
    @(negedge clk);
    reset = rst; req = rq; vs_in = v; vs_out = vo; lock_valid = lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    if (freeze !== x.f || ack !== x.ack || owner !== x.own ||
        frozen !== x.fr || nolock !== x.nl) begin
      failures++;
      $display("FAIL %s: got freeze=%b ack=%b owner=%0d frozen=%b nolock=%b, want freeze=%b ack=%b owner=%0d frozen=%b nolock=%b",
               x.name, freeze, ack, owner, frozen, nolock, x.f, x.ack, x.own, x.fr, x.nl);
    end
  endtask

  task automatic run_tbl(input vec_t t[$]);
    foreach (t[i]) step(t[i].rst, t[i].req, t[i].vs, t[i].vo, t[i].lk, t[i].e);
  endtask

  // ARM with no lock: freeze exactly 1000 cycles after ARM entry, nolock set.
  task automatic timeout_freeze(input string tag);
    step(0, 4'b0001, 0, 0, 0, mk(0, 4'b0000, 0, 0, 0, {tag, "_arm"}));
    for (int unsigned i = 1; i < 1000; i++)
      step(0, 4'b0001, 0, 0, 0, mk(0, 4'b0000, 0, 0, 0, {tag, "_wait"}));
    step(0, 4'b0001, 0, 0, 0, mk(1, 4'b0000, 0, 1, 1, {tag, "_forced"}));
    step(0, 4'b0001, 0, 0, 0, mk(1, 4'b0001, 0, 1, 1, {tag, "_ack"}));
  endtask

  initial begin
    reset = 1'b1; req = '0; vs_in = 1'b0; vs_out = 1'b0; lock_valid = 1'b1;

    // Lock present, req[2] mid-frame, then req[1]/req[3] and a full release.
    tbl_a.push_back(mv(1, 4'b0000, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "rst0")));
    tbl_a.push_back(mv(1, 4'b0000, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "rst1")));
    tbl_a.push_back(mv(0, 4'b0000, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "idle")));
    tbl_a.push_back(mv(0, 4'b0100, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "arm_enter")));
    tbl_a.push_back(mv(0, 4'b0100, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "arm_wait")));
    tbl_a.push_back(mv(0, 4'b0100, 1, 0, 1, mk(0, 4'b0000, 0, 0, 0, "vs_edge_1clk")));
    tbl_a.push_back(mv(0, 4'b0100, 1, 0, 1, mk(1, 4'b0000, 0, 1, 0, "freeze_2clk")));
    tbl_a.push_back(mv(0, 4'b0100, 1, 0, 1, mk(1, 4'b0100, 2, 1, 0, "ack2_own2")));
    tbl_a.push_back(mv(0, 4'b1110, 0, 0, 1, mk(1, 4'b1110, 1, 1, 0, "new_req_acked")));
    tbl_a.push_back(mv(0, 4'b1010, 0, 0, 1, mk(1, 4'b1010, 1, 1, 0, "drop_req2")));
    tbl_a.push_back(mv(0, 4'b1000, 0, 0, 1, mk(1, 4'b1000, 3, 1, 0, "drop_req1_own3")));
    tbl_a.push_back(mv(0, 4'b0000, 0, 1, 1, mk(1, 4'b0000, 3, 1, 0, "all_drop_hold")));
    tbl_a.push_back(mv(0, 4'b0000, 1, 0, 1, mk(1, 4'b0000, 3, 1, 0, "frame1")));
    tbl_a.push_back(mv(0, 4'b0000, 1, 1, 1, mk(1, 4'b0000, 3, 1, 0, "min_frames_hold")));
    tbl_a.push_back(mv(0, 4'b0000, 0, 0, 1, mk(1, 4'b0000, 3, 1, 0, "frame2")));
    tbl_a.push_back(mv(0, 4'b0000, 0, 0, 1, mk(1, 4'b0000, 3, 1, 0, "drain_enter")));
    tbl_a.push_back(mv(0, 4'b0000, 0, 0, 1, mk(1, 4'b0000, 3, 1, 0, "drain_wait")));
    tbl_a.push_back(mv(0, 4'b0000, 1, 0, 1, mk(1, 4'b0000, 3, 1, 0, "drain_vs_hi")));
    tbl_a.push_back(mv(0, 4'b0000, 1, 0, 1, mk(0, 4'b0000, 3, 0, 0, "release_on_vs")));

    // DRAIN re-raise keeps freeze and fcnt; req drop on the ARM vsync edge.
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 3, 0, 0, "rearm")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 3, 0, 0, "arm2")));
    tbl_b.push_back(mv(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 3, 0, 0, "arm2_vs")));
    tbl_b.push_back(mv(0, 4'b0001, 1, 0, 1, mk(1, 4'b0000, 3, 1, 0, "freeze2")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(1, 4'b0001, 0, 1, 0, "ack0_own0")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 1, 1, mk(1, 4'b0001, 0, 1, 0, "f2_frm_a")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(1, 4'b0001, 0, 1, 0, "f2_frm_b")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 1, 1, mk(1, 4'b0001, 0, 1, 0, "f2_frm_c")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(1, 4'b0001, 0, 1, 0, "f2_frm_d")));
    tbl_b.push_back(mv(0, 4'b0000, 0, 0, 1, mk(1, 4'b0000, 0, 1, 0, "to_drain")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(1, 4'b0000, 0, 1, 0, "drain_reraise")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(1, 4'b0001, 0, 1, 0, "reack")));
    tbl_b.push_back(mv(0, 4'b0000, 0, 0, 1, mk(1, 4'b0000, 0, 1, 0, "fcnt_kept_drain")));
    tbl_b.push_back(mv(0, 4'b0000, 1, 0, 1, mk(1, 4'b0000, 0, 1, 0, "drain2_vs_hi")));
    tbl_b.push_back(mv(0, 4'b0000, 1, 0, 1, mk(0, 4'b0000, 0, 0, 0, "release2")));
    tbl_b.push_back(mv(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "arm3")));
    tbl_b.push_back(mv(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 0, 0, 0, "arm3_vs_hi")));
    tbl_b.push_back(mv(0, 4'b0000, 1, 0, 1, mk(0, 4'b0000, 0, 0, 0, "drop_on_vs_rise")));
    tbl_b.push_back(mv(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 0, 0, 0, "rearm3")));
    tbl_b.push_back(mv(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 0, 0, 0, "arm3_no_edge")));
    tbl_b.push_back(mv(0, 4'b0000, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "idle3")));

    run_tbl(tbl_a);

`ifdef VIDEO_FREEZE_CTRL_HOLDOFF_EN
    // Requests during the 4-frame holdoff are ignored.
    for (int unsigned p = 0; p < 4; p++) begin
      step(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 3, 0, 0, "holdoff_lo"));
      step(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 3, 0, 0, "holdoff_lo"));
      step(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 3, 0, 0, "holdoff_hi"));
      step(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 3, 0, 0, "holdoff_hi"));
    end
    step(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 3, 0, 0, "ho_arm"));
    step(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 3, 0, 0, "ho_arm_wait"));
    step(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 3, 0, 0, "ho_vs_hi"));
    step(0, 4'b0001, 1, 0, 1, mk(1, 4'b0000, 3, 1, 0, "ho_freeze"));
    step(0, 4'b0001, 0, 0, 1, mk(1, 4'b0001, 0, 1, 0, "ho_ack"));
    step(1, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "ho_reset"));
`else
    run_tbl(tbl_b);
    timeout_freeze("to1");
    step(1, 4'b0001, 0, 0, 0, mk(0, 4'b0000, 0, 0, 0, "reset_mid_frozen"));
    step(0, 4'b0000, 0, 0, 0, mk(0, 4'b0000, 0, 0, 0, "post_reset_idle"));
    timeout_freeze("to2");
    step(0, 4'b0000, 0, 1, 0, mk(1, 4'b0000, 0, 1, 1, "to2_drop"));
    step(0, 4'b0000, 0, 0, 0, mk(1, 4'b0000, 0, 1, 1, "to2_frm1"));
    step(0, 4'b0000, 0, 1, 0, mk(1, 4'b0000, 0, 1, 1, "to2_frm1b"));
    step(0, 4'b0000, 0, 0, 0, mk(1, 4'b0000, 0, 1, 1, "to2_frm2"));
    step(0, 4'b0000, 0, 0, 0, mk(1, 4'b0000, 0, 1, 1, "to2_drain"));
    step(0, 4'b0000, 1, 0, 0, mk(1, 4'b0000, 0, 1, 1, "to2_drain_vs"));
    step(0, 4'b0000, 1, 0, 0, mk(0, 4'b0000, 0, 0, 1, "nolock_sticky"));
    step(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 0, 0, 1, "lk_arm"));
    step(0, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 0, 0, 1, "lk_arm_wait"));
    step(0, 4'b0001, 1, 0, 1, mk(0, 4'b0000, 0, 0, 1, "lk_vs_hi"));
    step(0, 4'b0001, 1, 0, 1, mk(1, 4'b0000, 0, 1, 0, "lock_clears_nolock"));
    step(0, 4'b0001, 1, 0, 1, mk(1, 4'b0001, 0, 1, 0, "lk_ack"));
    step(1, 4'b0001, 0, 0, 1, mk(0, 4'b0000, 0, 0, 0, "reset2"));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_freeze_ctrl.md
Name: video_freeze_ctrl

Overview:
- Arbitrates and sequences the shared video freezer between several requesters, e.g. core reset, ROM/tape loader and OSD menu.
- Asserts `freeze` only on a source vsync rising edge, and only once the freezer's sync_lock instances report valid timing.
- Releases `freeze` on a later source vsync rising edge, so the scaler/HDMI path sees no torn frame in either direction.
- Sits between the requesters and the freezer's `freeze` input, in the clk domain.

Parameters:
- NREQ, 4: number of freeze requesters (2..8).
- TO_W, 22: width of the watchdog counter.
- TIMEOUT, 22'd3_000_000: clk cycles without a qualifying source vsync before forcing a transition.
- MIN_FRAMES, 2: minimum regenerated frames (vs_out rising edges) held in FROZEN before release is allowed.

Ports:
- clk  in  1  video/system clock, same clk as the freezer.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  level freeze request per requester.
- ack  out  NREQ  per-requester grant: the video output is frozen and stable.
- owner  out  $clog2(NREQ)  lowest-index active requester while FROZEN.
- vs_in  in  1  source vsync, the same signal feeding the freezer's vs_in.
- vs_out  in  1  freezer output vsync (regenerated while frozen).
- lock_valid  in  1  AND of both sync_lock valid outputs.
- freeze  out  1  drives the freezer's freeze input.
- frozen  out  1  high in FROZEN and DRAIN.
- nolock  out  1  sticky flag: freeze was forced by timeout without lock.

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE; counters are 0.
  - Reset has priority over every other event.
- Input sampling:
  - vs_in and vs_out are registered once.
  - vs_rise = vs_in & ~vs_in_q; frm_rise is the same construction on vs_out.
- Watchdog:
  - tmo increments every cycle and clears on any state change.
  - tmo clears on vs_rise while in ARM or DRAIN.
- IDLE:
  - freeze = 0, ack = 0.
  - If |req, go to ARM next cycle.
- ARM:
  - freeze = 0.
  - If req == 0, go to IDLE. This has priority over every other ARM exit.
  - Else if lock_valid & vs_rise, go to FROZEN and clear nolock.
  - Else if tmo == TIMEOUT-1, go to FROZEN and set nolock.
- FROZEN:
  - freeze = 1, registered, so it is high from the first cycle in FROZEN.
  - Entry latency: freeze rises 2 clk after vs_in first goes high (1 cycle input register, 1 cycle state register).
  - fcnt counts frm_rise and saturates at MIN_FRAMES.
  - ack = req (registered, 1-cycle latency).
  - owner = lowest set index of req, registered; it holds its value when req == 0.
  - If req == 0 and fcnt >= MIN_FRAMES, go to DRAIN.
  - Requests newly raised while frozen are acked without re-arming.
- DRAIN:
  - freeze = 1, ack = 0.
  - If |req, return to FROZEN. fcnt is kept and freeze never drops.
  - Else if vs_rise or tmo == TIMEOUT-1, go to IDLE. freeze falls on entry to IDLE.
- Boundary conditions:
  - req drop and vs_rise in the same cycle in ARM: go to IDLE.
  - Requester drops mid-FROZEN while others remain: its ack falls next cycle; owner updates to the next lowest index.
  - fcnt clears on entry to FROZEN from ARM, not on entry from DRAIN.
  - The watchdog counter wraps harmlessly because it is cleared on state change; there are no TIMEOUT matches outside ARM and DRAIN.
  - Reset mid-FROZEN: freeze drops the next cycle, with no vsync alignment.

Optional Feature:
- Macro: VIDEO_FREEZE_CTRL_HOLDOFF_EN.
- Defined:
  - Adds state HOLDOFF between DRAIN and IDLE.
  - Adds parameter HOLDOFF_FRAMES, default 4.
  - HOLDOFF counts vs_rise up to HOLDOFF_FRAMES, or exits on watchdog timeout, before entering IDLE.
  - req is ignored during HOLDOFF. This prevents freeze thrash from a chattering requester.
- Undefined:
  - DRAIN goes directly to IDLE.
  - No extra state, counter or parameter exists.

Decomposition:
- Package video_freeze_ctrl_pkg holds:
  - the state enum (IDLE, ARM, FROZEN, DRAIN, HOLDOFF);
  - default TIMEOUT and MIN_FRAMES constants;
  - a lowest-set-index function used for owner.
- One sub-module, vfc_sync_watch, contains:
  - vs_in/vs_out registers and rise detectors;
  - the tmo watchdog with clear input and terminal-count output.
- The FSM stays in the top module.

Test Plan:
- Lock present, req[2] rises mid-frame → freeze rises exactly 2 clk after the next vs_in rising edge; ack[2] = 1 one cycle later; owner = 2; nolock = 0.
- lock_valid held 0, req[0] = 1, TIMEOUT = 1000 → freeze = 1 at cycle 1000 after ARM entry; nolock = 1.
- req[1] and req[3] frozen, req[1] drops → ack = 4'b1000, owner = 3, freeze stays 1; after req[3] drops and 2 vs_out edges, freeze falls on the next vs_in rising edge.
- In DRAIN, req[0] rises before the vs_in edge → freeze never deasserts and ack[0] = 1 next cycle; req[0] drops and rises again the same cycle as a vs_rise in ARM → state is IDLE, freeze stays 0.
- Reset pulsed while FROZEN → freeze, ack, frozen and nolock are 0 one cycle later; with VIDEO_FREEZE_CTRL_HOLDOFF_EN, req re-raised within 4 frames after release is not acked until HOLDOFF ends.
